// File: rtl/ram_stream_pkg.sv
// Shared definitions for the RAM stream reader: controller state encoding and
// the command length width derivation.
package ram_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 10;
   localparam int unsigned DEFAULT_DATA_WIDTH = 16;

   // One extra bit lets a single command cover the whole address space.
   function automatic int unsigned len_width(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/ram_stream_reader.sv
// Block read initiator: streams cmd_len words from a 1-cycle-latency RAM onto a
// valid/ready port. Optional checksum output enabled by RAM_STREAM_CKSUM_EN.
module ram_stream_reader
   import ram_stream_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned LEN_WIDTH  = len_width(ADDR_WIDTH)
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] o_sum
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;
   logic                  done_q, done_d;

   logic                  cmd_fire;
   logic                  beat_fire;
   logic                  rd_fire;

   // A read is only issued when the output register is free or emptying this
   // cycle; the RAM holding dout while re=0 keeps a stalled beat stable.
   assign cmd_ready = (state_q == IDLE);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign beat_fire = valid_q && o_ready;
   assign rd_fire   = (state_q == RUN) && (!valid_q || o_ready);

   assign mem_re   = rd_fire;
   assign mem_addr = ptr_q;
   assign o_valid  = valid_q;
   assign o_data   = mem_dout;
   assign o_last   = last_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = 1'b0;

      if (beat_fire) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      // A new read refills the output register in the same edge it drains.
      if (rd_fire) begin
         valid_d = 1'b1;
         last_d  = (rem_q == LEN_WIDTH'(1));
         ptr_d   = ptr_q + ADDR_WIDTH'(1);
         rem_d   = rem_q - LEN_WIDTH'(1);
      end

      case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               ptr_d = cmd_addr;
               rem_d = cmd_len;
               if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (rd_fire && (rem_q == LEN_WIDTH'(1))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (beat_fire && last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

`ifdef RAM_STREAM_CKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q, sum_d;

   // Accept and beat handshakes are mutually exclusive, so the sum is final
   // from the done pulse until the next command is taken.
   always_comb begin
      sum_d = sum_q;
      if (cmd_fire) begin
         sum_d = '0;
      end else if (beat_fire) begin
         sum_d = sum_q + mem_dout;
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign o_sum = sum_q;
`else
   assign o_sum = '0;
`endif

endmodule
